// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master program-BRAM arbiter.
package mem_arb_pkg;

   // Arbiter FSM states: idle, or owned by the loader (0) or the CPU (1).
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   // Read data returned to a master whose transaction was forced to complete.
   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

   // Master indices, as stored in the last-grant register.
   localparam logic M_LOADER = 1'b0;
   localparam logic M_CPU    = 1'b1;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing the program BRAM between the loader/monitor
// port (m0) and the CPU (m1). One outstanding transaction at a time, with a
// watchdog that force-completes a grant when the slave never answers.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int FIXED_PRIO     = 0
) (
   input  logic        clk,
   input  logic        reset_n,

   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,

   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   input  logic        m1_instr,

   output logic        s_valid,
   output logic        s_instr,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,

   output logic [1:0]  grant,
   output logic        timeout_err,
   input  logic        err_clear
);

   // A zero timeout disables the watchdog; keep the counter at least 1 bit.
   localparam bit              WDOG_EN = (TIMEOUT_CYCLES > 0);
   localparam int              CNT_W   = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q, timeout_err_d;
   logic             err_set;
   logic             expire;
   logic             pick_m1;

   // Watchdog fires in the granted cycle where the count hits the limit and
   // the slave still has not answered.
   assign expire = WDOG_EN && (state_q != IDLE) && (cnt_q == CNT_MAX) && !s_ready;

   // Request picker: a lone requester wins; a tie goes to m0 under fixed
   // priority, otherwise to whichever master was not granted last.
   always_comb begin
      pick_m1 = 1'b0;
      if (m1_valid && !m0_valid) begin
         pick_m1 = 1'b1;
      end else if (m0_valid && m1_valid) begin
         if (FIXED_PRIO != 0) begin
            pick_m1 = 1'b0;
         end else begin
            pick_m1 = (last_grant_q == M_LOADER);
         end
      end
   end

   // Next-state, watchdog counter and the combinational master/slave muxing.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      err_set      = 1'b0;
      s_valid      = 1'b0;
      s_instr      = 1'b0;
      s_addr       = '0;
      s_wdata      = '0;
      s_wstrb      = '0;
      m0_ready     = 1'b0;
      m0_rdata     = '0;
      m1_ready     = 1'b0;
      m1_rdata     = '0;
      grant        = 2'b00;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (m0_valid || m1_valid) begin
               if (pick_m1) begin
                  state_d      = GRANT1;
                  last_grant_d = M_CPU;
               end else begin
                  state_d      = GRANT0;
                  last_grant_d = M_LOADER;
               end
            end
         end

         GRANT0: begin
            grant   = 2'b01;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_wstrb = m0_wstrb;
            if (expire) begin
               m0_ready = 1'b1;
               m0_rdata = TIMEOUT_RDATA;
               err_set  = 1'b1;
               state_d  = IDLE;
            end else begin
               s_valid  = m0_valid;
               m0_ready = s_ready;
               m0_rdata = s_rdata;
               // Completion, or the master abandoned its request.
               if (s_ready || !m0_valid) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         GRANT1: begin
            grant   = 2'b10;
            s_instr = m1_instr;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_wstrb = m1_wstrb;
            if (expire) begin
               m1_ready = 1'b1;
               m1_rdata = TIMEOUT_RDATA;
               err_set  = 1'b1;
               state_d  = IDLE;
            end else begin
               s_valid  = m1_valid;
               m1_ready = s_ready;
               m1_rdata = s_rdata;
               if (s_ready || !m1_valid) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sticky error flag: a new expiry beats a clear arriving in the same cycle.
   always_comb begin
      timeout_err_d = timeout_err_q;
      if (err_set) begin
         timeout_err_d = 1'b1;
      end else if (err_clear) begin
         timeout_err_d = 1'b0;
      end
   end

   // State registers; last_grant resets to the CPU so the loader wins the
   // first tie after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         last_grant_q  <= M_CPU;
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance with a short
// watchdog and a fixed-priority instance share all master-side inputs; each
// has its own one-cycle-latency slave responder.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_valid, m1_valid, m1_instr, err_clear;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        slave_en;

   logic        m0_ready_a, m1_ready_a, s_valid_a, s_instr_a, s_ready_a, terr_a;
   logic [31:0] m0_rdata_a, m1_rdata_a, s_addr_a, s_wdata_a;
   logic [3:0]  s_wstrb_a;
   logic [1:0]  grant_a;
   logic        pend_a;

   logic        m0_ready_b, m1_ready_b, s_valid_b, s_instr_b, s_ready_b, terr_b;
   logic [31:0] m0_rdata_b, m1_rdata_b, s_addr_b, s_wdata_b;
   logic [3:0]  s_wstrb_b;
   logic [1:0]  grant_b;
   logic        pend_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(0)) dut_a (
      .clk(clk), .reset_n(reset_n),
      .m0_valid(m0_valid), .m0_ready(m0_ready_a), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata_a),
      .m1_valid(m1_valid), .m1_ready(m1_ready_a), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata_a),
      .m1_instr(m1_instr),
      .s_valid(s_valid_a), .s_instr(s_instr_a), .s_ready(s_ready_a),
      .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_wstrb(s_wstrb_a),
      .s_rdata(s_rdata), .grant(grant_a), .timeout_err(terr_a),
      .err_clear(err_clear)
   );

   mem_arbiter #(.FIXED_PRIO(1)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .m0_valid(m0_valid), .m0_ready(m0_ready_b), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata_b),
      .m1_valid(m1_valid), .m1_ready(m1_ready_b), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata_b),
      .m1_instr(m1_instr),
      .s_valid(s_valid_b), .s_instr(s_instr_b), .s_ready(s_ready_b),
      .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_wstrb(s_wstrb_b),
      .s_rdata(s_rdata), .grant(grant_b), .timeout_err(terr_b),
      .err_clear(err_clear)
   );

   // Slave models: answer one cycle after s_valid rises, when enabled.
   assign s_ready_a = pend_a & s_valid_a;
   assign s_ready_b = pend_b & s_valid_b;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_a <= 1'b0;
         pend_b <= 1'b0;
      end else begin
         pend_a <= slave_en & s_valid_a & ~s_ready_a;
         pend_b <= slave_en & s_valid_b & ~s_ready_b;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      m1_instr = 1'b0; err_clear = 1'b0; slave_en = 1'b0; s_rdata = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      clear_inputs();
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  ga [4];
      logic [1:0]  gb [4];
      int          na, nb, b_m1, gcyc, rp;
      logic [1:0]  prev_a, prev_b;
      bit          seen;
      logic [31:0] rd;
      logic        sv, terr_at;

      // Reset state, with both masters requesting throughout
      clear_inputs();
      reset_n  = 1'b0;
      m0_valid = 1'b1;
      m1_valid = 1'b1;
      step();
      step();
      chk("rst_grant", grant_a, 2'b00);
      chk("rst_s_valid", s_valid_a, 1'b0);
      chk("rst_m0_ready", m0_ready_a, 1'b0);
      chk("rst_m1_ready", m1_ready_a, 1'b0);
      chk("rst_terr", terr_a, 1'b0);
      chk("rst_grant_b", grant_b, 2'b00);

      // Single m1 instruction fetch
      do_reset();
      m1_valid = 1'b1; m1_addr = 32'h0; m1_wstrb = 4'h0; m1_instr = 1'b1;
      s_rdata  = 32'h00000013; slave_en = 1'b1;
      #1;
      chk("t1_idle_s_valid", s_valid_a, 1'b0);
      step();
      chk("t1_grant", grant_a, 2'b10);
      chk("t1_s_valid", s_valid_a, 1'b1);
      chk("t1_s_instr", s_instr_a, 1'b1);
      chk("t1_s_addr", s_addr_a, 32'h0);
      chk("t1_ready_early", m1_ready_a, 1'b0);
      m1_instr = 1'b0;
      #1;
      chk("t1_s_instr_follow", s_instr_a, 1'b0);
      m1_instr = 1'b1;
      step();
      chk("t1_m1_ready", m1_ready_a, 1'b1);
      chk("t1_m1_rdata", m1_rdata_a, 32'h00000013);
      chk("t1_m0_rdata", m0_rdata_a, 32'h0);
      chk("t1_m0_ready", m0_ready_a, 1'b0);
      m1_valid = 1'b0;
      step();
      chk("t1_back_idle", grant_a, 2'b00);
      chk("t1_idle_s_valid2", s_valid_a, 1'b0);

      // Continuous contention: round-robin vs fixed priority
      do_reset();
      m0_valid = 1'b1; m0_addr = 32'hC; m0_wdata = 32'hFF5FF06F; m0_wstrb = 4'hF;
      m1_valid = 1'b1; m1_addr = 32'h4; m1_wstrb = 4'h0;
      s_rdata  = 32'h00000013; slave_en = 1'b1;
      step();
      chk("t2_first_grant", grant_a, 2'b01);
      chk("t2_s_addr", s_addr_a, 32'hC);
      chk("t2_s_wdata", s_wdata_a, 32'hFF5FF06F);
      chk("t2_s_wstrb", s_wstrb_a, 4'hF);
      chk("t2_other_rdata", m1_rdata_a, 32'h0);
      ga[0] = grant_a; na = 1; prev_a = grant_a;
      gb[0] = grant_b; nb = 1; prev_b = grant_b;
      b_m1 = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (grant_a != 2'b00 && prev_a == 2'b00 && na < 4) begin
            ga[na] = grant_a; na++;
         end
         if (grant_b != 2'b00 && prev_b == 2'b00 && nb < 4) begin
            gb[nb] = grant_b; nb++;
         end
         if (grant_b == 2'b10) b_m1++;
         prev_a = grant_a;
         prev_b = grant_b;
      end
      chk("t2_rr_count", na, 4);
      chk("t2_rr_g0", ga[0], 2'b01);
      chk("t2_rr_g1", ga[1], 2'b10);
      chk("t2_rr_g2", ga[2], 2'b01);
      chk("t2_rr_g3", ga[3], 2'b10);
      chk("t3_fp_count", nb, 4);
      chk("t3_fp_g1", gb[1], 2'b01);
      chk("t3_fp_g3", gb[3], 2'b01);
      chk("t3_fp_m1_never", b_m1, 0);
      m0_valid = 1'b0; m1_valid = 1'b0;

      // Watchdog expiry with a silent slave
      do_reset();
      m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
      gcyc = 0; seen = 1'b0; rd = '0; sv = 1'b1; terr_at = 1'b1;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         if (grant_a == 2'b01) gcyc++;
         if (m0_ready_a) begin
            seen = 1'b1; rd = m0_rdata_a; sv = s_valid_a; terr_at = terr_a;
         end
      end
      chk("t4_seen", seen, 1'b1);
      chk("t4_grant_cycles", gcyc, 9);
      chk("t4_rdata", rd, 32'hDEADBEEF);
      chk("t4_s_valid_low", sv, 1'b0);
      chk("t4_terr_not_yet", terr_at, 1'b0);
      m0_valid = 1'b0;
      step();
      chk("t4_terr_set", terr_a, 1'b1);
      chk("t4_idle", grant_a, 2'b00);
      step();
      step();
      chk("t4_terr_sticky", terr_a, 1'b1);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      chk("t4_terr_cleared", terr_a, 1'b0);

      // Expiry coinciding with err_clear: set wins
      err_clear = 1'b1; m0_valid = 1'b1; seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         if (m0_ready_a) seen = 1'b1;
      end
      chk("t4b_seen", seen, 1'b1);
      step();
      err_clear = 1'b0; m0_valid = 1'b0;
      chk("t4b_set_wins", terr_a, 1'b1);

      // Asynchronous reset in the middle of an m1 grant
      do_reset();
      m1_valid = 1'b1; m1_addr = 32'h8; m1_wstrb = 4'h0; s_rdata = 32'h00000013;
      step();
      chk("t5_grant", grant_a, 2'b10);
      chk("t5_s_valid", s_valid_a, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t5_async_s_valid", s_valid_a, 1'b0);
      chk("t5_async_grant", grant_a, 2'b00);
      chk("t5_async_ready", m1_ready_a, 1'b0);
      step();
      reset_n = 1'b1; slave_en = 1'b1;
      step();
      chk("t5_regrant", grant_a, 2'b10);
      step();
      chk("t5_ready", m1_ready_a, 1'b1);
      chk("t5_rdata", m1_rdata_a, 32'h00000013);
      m1_valid = 1'b0;
      step();

      // m1 abandons its request before the slave answers
      do_reset();
      m1_valid = 1'b1; m1_addr = 32'h20;
      step();
      chk("t6_grant", grant_a, 2'b10);
      step();
      m1_valid = 1'b0;
      #1;
      chk("t6_s_valid_drop", s_valid_a, 1'b0);
      chk("t6_no_ready", m1_ready_a, 1'b0);
      step();
      chk("t6_idle", grant_a, 2'b00);
      rp = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (m1_ready_a) rp++;
      end
      chk("t6_no_ready_later", rp, 0);
      chk("t6_no_terr", terr_a, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mem_arbiter
